// File: rtl/addsub_sequencer_pkg.sv
// Shared types and encodings for the add/subtract accumulate sequencer.
// ctrl_for() maps a state onto the registered datapath controls.
package addsub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_OP_B,
    ST_OP_C,
    ST_OP_D,
    ST_FINISH
  } state_t;

  localparam int NUM_OPS = 3;

  localparam logic [1:0] SEL_B = 2'b00;
  localparam logic [1:0] SEL_C = 2'b01;
  localparam logic [1:0] SEL_D = 2'b10;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

  typedef struct packed {
    logic       s0;
    logic [1:0] sel;      // {s2,s1}
    logic       add_sub;
    logic       done;
    logic       busy;
    logic       valid;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '{s0: 1'b0, sel: SEL_B, add_sub: OP_ADD,
                                 done: 1'b1, busy: 1'b0, valid: 1'b0};

  function automatic logic [1:0] eff_terms(input logic [1:0] n);
    return (n == 2'd0) ? 2'd1 : n;
  endfunction

  // Selects and add/sub are left untouched where a state does not own them,
  // so the datapath result stays stable while idle.
  function automatic ctrl_t ctrl_for(input state_t st, input logic [NUM_OPS-1:0] ops,
                                     input ctrl_t prev);
    ctrl_t c;
    c       = prev;
    c.valid = 1'b0;
    case (st)
      ST_LOAD_A: begin
        c.s0   = 1'b0;
        c.sel  = SEL_B;
        c.done = 1'b1;
        c.busy = 1'b1;
      end
      ST_OP_B: begin
        c.s0      = 1'b1;
        c.sel     = SEL_B;
        c.add_sub = ops[0];
        c.done    = 1'b0;
        c.busy    = 1'b1;
      end
      ST_OP_C: begin
        c.s0      = 1'b1;
        c.sel     = SEL_C;
        c.add_sub = ops[1];
        c.done    = 1'b0;
        c.busy    = 1'b1;
      end
      ST_OP_D: begin
        c.s0      = 1'b1;
        c.sel     = SEL_D;
        c.add_sub = ops[2];
        c.done    = 1'b0;
        c.busy    = 1'b1;
      end
      ST_FINISH: begin
        c.s0    = 1'b1;
        c.done  = 1'b1;
        c.busy  = 1'b0;
        c.valid = 1'b1;
      end
      default: begin
        c.s0   = 1'b1;
        c.done = 1'b1;
        c.busy = 1'b0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/addsub_sequencer_if.sv
// Request/control bundle between a requester and the accumulate sequencer.
interface addsub_sequencer_if;
  import addsub_pkg::*;

  logic               start;
  logic [1:0]         num_terms;
  logic [NUM_OPS-1:0] ops;
  logic               s0;
  logic               s1;
  logic               s2;
  logic               addOrSub;
  logic               done;
  logic               busy;
  logic               valid;

  modport master (
    output start, num_terms, ops,
    input  s0, s1, s2, addOrSub, done, busy, valid
  );

  modport slave (
    input  start, num_terms, ops,
    output s0, s1, s2, addOrSub, done, busy, valid
  );

endinterface

// File: rtl/addsub_sequencer_step_timer.sv
// Per-state dwell counter: expire is high in the last cycle of a step.
module step_timer (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic [3:0] limit,
  output logic       expire
);

  logic [3:0] r_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)     r_cnt <= '0;
    else if (clear) r_cnt <= '0;
    else            r_cnt <= r_cnt + 4'd1;
  end

  assign expire = (r_cnt == (limit - 4'd1));

endmodule

// File: rtl/addsub_sequencer.sv
// Sequences LOAD_A then up to three add/sub steps on an external accumulator,
// holding each step STEP_CYCLES cycles and pulsing valid when the result is final.
module addsub_sequencer
  import addsub_pkg::*;
#(
  parameter int STEP_CYCLES = 1
) (
  input  logic              clock,
  input  logic              reset,
  addsub_sequencer_if.slave bus
);

  localparam logic [3:0] STEP_LIM = 4'(STEP_CYCLES);

  state_t             r_state;
  logic [1:0]         r_terms;
  logic [NUM_OPS-1:0] r_ops;
  ctrl_t              r_ctrl;
  logic               w_expire;
  logic               w_clear;

  // Holding the timer clear outside the timed states guarantees a zero count
  // on every entry; the expire edge clears it on state-to-state moves.
  assign w_clear = w_expire | (r_state == ST_IDLE) | (r_state == ST_FINISH);

  step_timer u_step (
    .clock  (clock),
    .reset  (reset),
    .clear  (w_clear),
    .limit  (STEP_LIM),
    .expire (w_expire)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_terms <= '0;
      r_ops   <= '0;
      r_ctrl  <= CTRL_RST;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.start) begin
            r_terms <= eff_terms(bus.num_terms);
            r_ops   <= bus.ops;
            r_state <= ST_LOAD_A;
            r_ctrl  <= ctrl_for(ST_LOAD_A, r_ops, r_ctrl);
          end else begin
            r_ctrl  <= ctrl_for(ST_IDLE, r_ops, r_ctrl);
          end
        end
        ST_LOAD_A: begin
          if (w_expire) begin
            r_state <= ST_OP_B;
            r_ctrl  <= ctrl_for(ST_OP_B, r_ops, r_ctrl);
          end
        end
        ST_OP_B: begin
          if (w_expire) begin
            if (r_terms == 2'd1) begin
              r_state <= ST_FINISH;
              r_ctrl  <= ctrl_for(ST_FINISH, r_ops, r_ctrl);
            end else begin
              r_state <= ST_OP_C;
              r_ctrl  <= ctrl_for(ST_OP_C, r_ops, r_ctrl);
            end
          end
        end
        ST_OP_C: begin
          if (w_expire) begin
            if (r_terms == 2'd2) begin
              r_state <= ST_FINISH;
              r_ctrl  <= ctrl_for(ST_FINISH, r_ops, r_ctrl);
            end else begin
              r_state <= ST_OP_D;
              r_ctrl  <= ctrl_for(ST_OP_D, r_ops, r_ctrl);
            end
          end
        end
        ST_OP_D: begin
          if (w_expire) begin
            r_state <= ST_FINISH;
            r_ctrl  <= ctrl_for(ST_FINISH, r_ops, r_ctrl);
          end
        end
        ST_FINISH: begin
          r_state <= ST_IDLE;
          r_ctrl  <= ctrl_for(ST_IDLE, r_ops, r_ctrl);
        end
        default: begin
          r_state <= ST_IDLE;
          r_ctrl  <= ctrl_for(ST_IDLE, r_ops, r_ctrl);
        end
      endcase
    end
  end

  assign bus.s0       = r_ctrl.s0;
  assign bus.s1       = r_ctrl.sel[0];
  assign bus.s2       = r_ctrl.sel[1];
  assign bus.addOrSub = r_ctrl.add_sub;
  assign bus.done     = r_ctrl.done;
  assign bus.busy     = r_ctrl.busy;
  assign bus.valid    = r_ctrl.valid;

endmodule
